// File: rtl/fetch_unit.sv
// Instruction fetch stage with a single outstanding memory request.
//
// Issues one instruction-memory request per fetch, waits for its response and
// writes the fetched word into the IF/ID pipeline register. A redirect (br_sel)
// flushes IF/ID to a NOP bubble. If a request is still in flight when the
// redirect arrives, its wrong-path response is later discarded.
//
// Ports
//   i_clk, i_rst        clock; synchronous active-high reset
//   pc                  current fetch PC from the PC register
//   br_sel              one-cycle redirect/flush pulse from execute
//   StallD              decode stall; holds the IF/ID register
//   imem_req_*          request channel to instruction memory (addr = pc)
//   imem_rsp_*          response channel from instruction memory
//   pc_four             pc + 4 (combinational), next sequential PC
//   StallF              holds the PC register when high
//   instr_D, pc_D,      registered IF/ID outputs
//   valid_D
module fetch_unit (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic [31:0] pc,
   input  logic        br_sel,
   input  logic        StallD,
   input  logic        imem_req_ready,
   input  logic        imem_rsp_valid,
   input  logic [31:0] imem_rsp_data,
   output logic [31:0] pc_four,
   output logic        StallF,
   output logic        imem_req_valid,
   output logic [31:0] imem_req_addr,
   output logic        imem_rsp_ready,
   output logic [31:0] instr_D,
   output logic [31:0] pc_D,
   output logic        valid_D
);

   localparam logic [31:0] NopInstr = 32'h00000013;  // addi x0, x0, 0

   typedef enum logic [1:0] {
      S_REQ  = 2'd0,
      S_WAIT = 2'd1,
      S_DROP = 2'd2
   } state_e;

   state_e      state_q, state_d;
   logic [31:0] req_pc_q, req_pc_d;
   logic [31:0] instr_q, instr_d;
   logic [31:0] pcd_q, pcd_d;
   logic        valid_q, valid_d;

   logic        rsp_hs;
   logic        load;

   assign pc_four       = pc + 32'd4;
   assign imem_req_addr = pc;
   // A redirect always releases the PC so the target gets loaded.
   assign StallF        = !br_sel && !((state_q == S_REQ) && imem_req_ready);

   // Response acceptance; in S_WAIT only when IF/ID has room for the word.
   always_comb begin
      imem_rsp_ready = 1'b0;
      unique case (state_q)
         S_WAIT:  imem_rsp_ready = !(valid_q && StallD);
         S_DROP:  imem_rsp_ready = 1'b1;
         default: imem_rsp_ready = 1'b0;
      endcase
   end

   assign rsp_hs = imem_rsp_valid && imem_rsp_ready;

   // Next state, request strobe and load decision.
   always_comb begin
      state_d        = state_q;
      req_pc_d       = req_pc_q;
      imem_req_valid = 1'b0;
      load           = 1'b0;
      unique case (state_q)
         S_REQ: begin
            imem_req_valid = 1'b1;
            if (imem_req_ready) begin
               req_pc_d = pc;
               state_d  = br_sel ? S_DROP : S_WAIT;
            end
         end
         S_WAIT: begin
            if (rsp_hs) begin
               // A coincident redirect makes this response wrong-path.
               load    = !br_sel;
               state_d = S_REQ;
            end else if (br_sel) begin
               state_d = S_DROP;
            end
         end
         S_DROP: begin
            // The in-flight response is discarded; once it is gone nothing
            // is outstanding, so a fresh request may be issued.
            if (rsp_hs) begin
               state_d = S_REQ;
            end
         end
         default: state_d = S_REQ;
      endcase
   end

   // IF/ID register: flush beats load beats hold beats bubble.
   always_comb begin
      instr_d = instr_q;
      pcd_d   = pcd_q;
      valid_d = valid_q;
      if (br_sel) begin
         instr_d = NopInstr;
         valid_d = 1'b0;
      end else if (load) begin
         instr_d = imem_rsp_data;
         pcd_d   = req_pc_q;
         valid_d = 1'b1;
      end else if (!StallD) begin
         instr_d = NopInstr;
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q  <= S_REQ;
         req_pc_q <= 32'h0;
         instr_q  <= NopInstr;
         pcd_q    <= 32'h0;
         valid_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         req_pc_q <= req_pc_d;
         instr_q  <= instr_d;
         pcd_q    <= pcd_d;
         valid_q  <= valid_d;
      end
   end

   assign instr_D = instr_q;
   assign pc_D    = pcd_q;
   assign valid_D = valid_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit. A transaction-level model (outstanding flag,
// wrong-path flag, IF/ID contents) is checked against the DUT on every falling
// edge; literal expectations along the directed sequence pin the model.
module tb_fetch_unit;

   localparam logic [31:0] Nop = 32'h00000013;

   logic        i_clk = 1'b0;
   logic        i_rst;
   logic [31:0] pc;
   logic        br_sel;
   logic        StallD;
   logic        imem_req_ready;
   logic        imem_rsp_valid;
   logic [31:0] imem_rsp_data;
   logic [31:0] pc_four;
   logic        StallF;
   logic        imem_req_valid;
   logic [31:0] imem_req_addr;
   logic        imem_rsp_ready;
   logic [31:0] instr_D;
   logic [31:0] pc_D;
   logic        valid_D;

   int n_tests = 0;
   int n_fail  = 0;

   fetch_unit dut (
      .i_clk          (i_clk),
      .i_rst          (i_rst),
      .pc             (pc),
      .br_sel         (br_sel),
      .StallD         (StallD),
      .imem_req_ready (imem_req_ready),
      .imem_rsp_valid (imem_rsp_valid),
      .imem_rsp_data  (imem_rsp_data),
      .pc_four        (pc_four),
      .StallF         (StallF),
      .imem_req_valid (imem_req_valid),
      .imem_req_addr  (imem_req_addr),
      .imem_rsp_ready (imem_rsp_ready),
      .instr_D        (instr_D),
      .pc_D           (pc_D),
      .valid_D        (valid_D)
   );

   always #5 i_clk = ~i_clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- transaction-level model ----------------
   logic        m_ok = 1'b0;   // model valid after first reset edge
   logic        m_busy;        // a request is outstanding
   logic        m_drop;        // the outstanding response is wrong-path
   logic [31:0] m_rpc;
   logic [31:0] m_instr;
   logic [31:0] m_pcd;
   logic        m_valid;

   logic e_req_valid, e_rsp_ready, e_stallf, e_take, e_load;
   assign e_req_valid = !m_busy;
   assign e_rsp_ready = m_busy && (m_drop || !(m_valid && StallD));
   assign e_stallf    = !br_sel && !(!m_busy && imem_req_ready);
   assign e_take      = m_busy && imem_rsp_valid && e_rsp_ready;
   assign e_load      = e_take && !m_drop && !br_sel;

   always @(posedge i_clk) begin
      if (i_rst) begin
         m_ok    <= 1'b1;
         m_busy  <= 1'b0;
         m_drop  <= 1'b0;
         m_rpc   <= 32'h0;
         m_instr <= Nop;
         m_pcd   <= 32'h0;
         m_valid <= 1'b0;
      end else begin
         if (!m_busy) begin
            if (imem_req_ready) begin
               m_busy <= 1'b1;
               m_drop <= br_sel;
               m_rpc  <= pc;
            end
         end else if (e_take) begin
            m_busy <= 1'b0;
            m_drop <= 1'b0;
         end else if (br_sel) begin
            m_drop <= 1'b1;
         end
         if (br_sel) begin
            m_valid <= 1'b0;
            m_instr <= Nop;
         end else if (e_load) begin
            m_valid <= 1'b1;
            m_instr <= imem_rsp_data;
            m_pcd   <= m_rpc;
         end else if (!StallD) begin
            m_valid <= 1'b0;
            m_instr <= Nop;
         end
      end
   end

   // Compare process: every falling edge once the model is live.
   always @(negedge i_clk) begin
      if (m_ok) begin
         check("pc_four", pc_four, pc + 32'd4);
         check("StallF", {31'b0, StallF}, {31'b0, e_stallf});
         check("req_valid", {31'b0, imem_req_valid}, {31'b0, e_req_valid});
         check("req_addr", imem_req_addr, pc);
         check("rsp_ready", {31'b0, imem_rsp_ready}, {31'b0, e_rsp_ready});
         check("instr_D", instr_D, m_instr);
         check("pc_D", pc_D, m_pcd);
         check("valid_D", {31'b0, valid_D}, {31'b0, m_valid});
      end
   end

   task automatic step();
      @(posedge i_clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   // ---------------- directed stimulus ----------------
   initial begin
      i_rst          = 1'b1;
      pc             = 32'h0;
      br_sel         = 1'b0;
      StallD         = 1'b0;
      imem_req_ready = 1'b0;
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = 32'h0;
      step();
      step();
      check("rst_valid", {31'b0, valid_D}, 32'd0);
      check("rst_instr", instr_D, Nop);
      check("rst_pcd", pc_D, 32'h0);
      i_rst = 1'b0;

      // Basic fetch: request at 0x100, response one cycle later.
      pc = 32'h100; imem_req_ready = 1'b1;
      settle();
      check("r030_req_valid", {31'b0, imem_req_valid}, 32'd1);
      check("r030_req_addr", imem_req_addr, 32'h100);
      check("r030_stallf", {31'b0, StallF}, 32'd0);
      step();
      imem_req_ready = 1'b0; imem_rsp_valid = 1'b1; imem_rsp_data = 32'h00500093;
      step();
      check("r030_instr", instr_D, 32'h00500093);
      check("r030_pcd", pc_D, 32'h100);
      check("r030_valid", {31'b0, valid_D}, 32'd1);

      // Decode stall backpressures the response.
      imem_rsp_valid = 1'b0; StallD = 1'b1; pc = 32'h104; imem_req_ready = 1'b1;
      step();
      imem_req_ready = 1'b0; imem_rsp_valid = 1'b1; imem_rsp_data = 32'h00A00113;
      settle();
      check("r031_rsp_ready_stall", {31'b0, imem_rsp_ready}, 32'd0);
      step();
      check("r031_hold_instr", instr_D, 32'h00500093);
      check("r031_hold_valid", {31'b0, valid_D}, 32'd1);
      StallD = 1'b0;
      settle();
      check("r031_rsp_ready_go", {31'b0, imem_rsp_ready}, 32'd1);
      step();
      check("r031_instr", instr_D, 32'h00A00113);
      check("r031_pcd", pc_D, 32'h104);
      imem_rsp_valid = 1'b0;

      // Redirect while waiting; late response must be dropped.
      pc = 32'h108; imem_req_ready = 1'b1;
      step();
      check("r032_bubble", {31'b0, valid_D}, 32'd0);
      imem_req_ready = 1'b0; br_sel = 1'b1;
      settle();
      check("r032_stallf_br", {31'b0, StallF}, 32'd0);
      step();
      br_sel = 1'b0; pc = 32'h200;
      settle();
      check("r032_no_req_drop", {31'b0, imem_req_valid}, 32'd0);
      imem_rsp_valid = 1'b1; imem_rsp_data = 32'hDEADBEEF;
      settle();
      check("r032_drop_ready", {31'b0, imem_rsp_ready}, 32'd1);
      step();
      check("r032_valid", {31'b0, valid_D}, 32'd0);
      check("r032_instr", instr_D, Nop);
      imem_rsp_valid = 1'b0;
      settle();
      check("r032_req_valid", {31'b0, imem_req_valid}, 32'd1);
      check("r032_req_addr", imem_req_addr, 32'h200);
      check("r032_stallf_idle", {31'b0, StallF}, 32'd1);
      imem_req_ready = 1'b1;
      step();
      imem_req_ready = 1'b0; imem_rsp_valid = 1'b1; imem_rsp_data = 32'h00000033;
      step();
      check("r032_tgt_instr", instr_D, 32'h00000033);
      check("r032_tgt_pcd", pc_D, 32'h200);
      imem_rsp_valid = 1'b0;

      // Redirect coincident with request handshake.
      pc = 32'h204; imem_req_ready = 1'b1; br_sel = 1'b1;
      step();
      check("r033_flush_valid", {31'b0, valid_D}, 32'd0);
      br_sel = 1'b0; imem_req_ready = 1'b0; pc = 32'h300;
      settle();
      check("r033_no_req", {31'b0, imem_req_valid}, 32'd0);
      imem_rsp_valid = 1'b1; imem_rsp_data = 32'h11111111;
      step();
      check("r033_valid", {31'b0, valid_D}, 32'd0);
      check("r033_instr", instr_D, Nop);
      imem_rsp_valid = 1'b0;

      // Redirect coincident with response handshake.
      imem_req_ready = 1'b1;
      step();
      imem_req_ready = 1'b0; imem_rsp_valid = 1'b1; imem_rsp_data = 32'h22222222;
      br_sel = 1'b1;
      step();
      br_sel = 1'b0; imem_rsp_valid = 1'b0;
      settle();
      check("wbr_valid", {31'b0, valid_D}, 32'd0);
      check("wbr_req_valid", {31'b0, imem_req_valid}, 32'd1);

      // Reset in the middle of an outstanding request.
      pc = 32'h400; imem_req_ready = 1'b1;
      step();
      imem_req_ready = 1'b0; imem_rsp_valid = 1'b1; imem_rsp_data = 32'h00400413;
      step();
      check("r034_pre_valid", {31'b0, valid_D}, 32'd1);
      imem_rsp_valid = 1'b0; pc = 32'h404; imem_req_ready = 1'b1; StallD = 1'b1;
      step();
      imem_req_ready = 1'b0; i_rst = 1'b1;
      step();
      check("r034_valid", {31'b0, valid_D}, 32'd0);
      check("r034_instr", instr_D, Nop);
      check("r034_pcd", pc_D, 32'h0);
      check("r034_req_valid", {31'b0, imem_req_valid}, 32'd1);
      i_rst = 1'b0; imem_rsp_valid = 1'b1; imem_rsp_data = 32'h33333333;
      settle();
      check("r029_rsp_ready", {31'b0, imem_rsp_ready}, 32'd0);
      StallD = 1'b0;
      step();
      check("r029_valid", {31'b0, valid_D}, 32'd0);
      imem_rsp_valid = 1'b0;

      // pc_four wrap and a plain value.
      pc = 32'hFFFFFFFC;
      settle();
      check("r035_wrap", pc_four, 32'h00000000);
      pc = 32'h7FFFFFFF;
      settle();
      check("r035_plain", pc_four, 32'h80000003);
      step();
      step();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have port: i_clk  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL have port: i_rst  input  1  reset, synchronous, active-high.
REQ-003 SHALL have port: pc  input  32  current fetch PC from the PC register.
REQ-004 SHALL have port: br_sel  input  1  redirect/flush from execute stage; single-cycle pulse.
REQ-005 SHALL have port: StallD  input  1  decode stage stall; holds IF/ID outputs.
REQ-006 SHALL have port: imem_req_ready  input  1  instruction memory accepts request.
REQ-007 SHALL have port: imem_rsp_valid  input  1  instruction memory response valid.
REQ-008 SHALL have port: imem_rsp_data  input  32  fetched instruction word.
REQ-009 SHALL have port: pc_four  output  32  pc + 4, combinational, to PC register.
REQ-010 SHALL have port: StallF  output  1  holds the PC register when high.
REQ-011 SHALL have port: imem_req_valid  output  1  request strobe.
REQ-012 SHALL have port: imem_req_addr  output  32  request address; equals pc.
REQ-013 SHALL have port: imem_rsp_ready  output  1  response accepted when high with imem_rsp_valid.
REQ-014 SHALL have ports: instr_D, pc_D (32 each), valid_D (1): registered IF/ID outputs.

Function
REQ-015 SHALL implement FSM states S_REQ, S_WAIT, S_DROP; at most one outstanding memory request.
REQ-016 S_REQ: imem_req_valid=1, imem_req_addr=pc; on imem_req_valid&imem_req_ready latch req_pc<=pc, go S_WAIT (S_DROP if br_sel same cycle).
REQ-017 S_WAIT: stay until response handshake; on handshake with no br_sel, load instr_D<=imem_rsp_data, pc_D<=req_pc, valid_D<=1, go S_REQ.
REQ-018 S_WAIT with br_sel=1 and no response handshake: go S_DROP; with br_sel and handshake same cycle: discard data, go S_REQ.
REQ-019 S_DROP: discard next handshaked response, go S_REQ; br_sel in S_DROP keeps S_DROP.
REQ-020 imem_req_valid SHALL be 0 in S_WAIT and S_DROP.
REQ-021 imem_rsp_ready = 1 in S_DROP; in S_WAIT = !(valid_D & StallD); 0 in S_REQ.
REQ-022 StallF = !br_sel & !(state==S_REQ & imem_req_ready); br_sel SHALL always deassert StallF so the redirect target loads.
REQ-023 imem_req_addr may change without handshake only in a cycle following br_sel=1.
REQ-024 br_sel=1 SHALL clear valid_D and set instr_D=32'h00000013 at next edge, overriding StallD.
REQ-025 StallD=1 and no br_sel SHALL hold instr_D, pc_D, valid_D.
REQ-026 When no new instruction is loaded and StallD=0, valid_D<=0, instr_D<=32'h00000013 (bubble).
REQ-027 pc_four SHALL wrap modulo 2^32 (32'hFFFFFFFC -> 32'h00000000).

Reset
REQ-028 i_rst=1 at a clock edge SHALL set state=S_REQ, req_pc=0, pc_D=0, instr_D=32'h00000013, valid_D=0, overriding all other inputs.
REQ-029 Responses arriving after a mid-request reset SHALL be accepted only under REQ-021 for state S_REQ (i.e. not accepted); memory is reset alongside.

Verification
REQ-030 pc=0x100, req_ready=1, rsp one cycle later with 0x00500093 -> instr_D=0x00500093, pc_D=0x100, valid_D=1 two edges after request.
REQ-031 S_WAIT, rsp_valid with valid_D=1, StallD=1 -> imem_rsp_ready=0, IF/ID held; StallD drops -> handshake, new instr loads next edge.
REQ-032 br_sel pulse in S_WAIT, rsp 0xDEADBEEF arrives later -> discarded, valid_D=0, next request address = redirect target, StallF=0 during br_sel.
REQ-033 br_sel coincident with request handshake -> S_DROP, wrong-path response dropped, valid_D stays 0.
REQ-034 i_rst asserted in S_WAIT -> next edge state S_REQ, valid_D=0, instr_D=0x00000013, pc_D=0.
REQ-035 pc=0xFFFFFFFC -> pc_four=0x00000000.
